// File: rtl/imem_fetch_port.sv
// imem_fetch_port: instruction memory with a host load port and a
// valid/ready fetch port. A LOAD/RUN/DRAIN mode FSM arbitrates between
// program download and CPU fetch.
// Optional build macro: IMEM_PARITY_EN stores an even-parity bit per word
// and flags mismatches on fetch through rsp_perr.
module imem_fetch_port #(
    parameter int DEPTH      = 256,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  ld_en,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  ld_done,
    input  logic                  ld_start,
    output logic [ADDR_WIDTH:0]   ld_cnt,
    output logic [1:0]            mode,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  rsp_perr
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } state_t;

`ifdef IMEM_PARITY_EN
    localparam int MEM_W = DATA_WIDTH + 1;
`else
    localparam int MEM_W = DATA_WIDTH;
`endif

    // Compared in ADDR_WIDTH+1 bits so DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_MAX = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

    state_t            state, state_nxt;
    logic [MEM_W-1:0]  mem [0:DEPTH-1];
    logic              ld_in_range;
    logic              req_in_range;
    logic              ld_write;
    logic              accept;
    logic              rsp_fire;
    logic [MEM_W-1:0]  rd_word;
    logic [MEM_W-1:0]  wr_word;
    logic              rd_perr;

    assign ld_in_range  = {1'b0, ld_addr} < DEPTH_L;
    assign req_in_range = {1'b0, req_addr} < DEPTH_L;
    assign ld_write     = (state == ST_LOAD) && ld_en && ld_in_range;
    assign req_ready    = (state == ST_RUN) && (!rsp_valid || rsp_ready);
    assign accept       = req_valid && req_ready;
    assign rsp_fire     = rsp_valid && rsp_ready;
    assign mode         = state;
    assign rd_word      = mem[req_addr];

`ifdef IMEM_PARITY_EN
    assign wr_word = {^ld_data, ld_data};
    assign rd_perr = ^rd_word;
`else
    assign wr_word = ld_data;
    assign rd_perr = 1'b0;
`endif

    // Mode state register.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rstn) state <= ST_LOAD;
        else       state <= state_nxt;
    end

    // Next-mode decode; ld_start/ld_done outside their own mode are ignored.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_nxt unassigned
        // (which would infer a latch).
        state_nxt = state;
        unique case (state)
            ST_LOAD:  if (ld_done)  state_nxt = ST_RUN;
            ST_RUN:   if (ld_start) state_nxt = ST_DRAIN;
            ST_DRAIN: if (!rsp_valid || rsp_ready) state_nxt = ST_LOAD;
            default:  state_nxt = ST_LOAD;
        endcase
    end

    // Program storage written from the load port.
    always_ff @(posedge clk) begin
        // NOTE: the array deliberately has no reset so it maps onto RAM and
        // keeps its contents across a reset.
        if (ld_write) mem[ld_addr] <= wr_word;
    end

    // Saturating count of in-range words written during the current LOAD session.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ld_cnt <= '0;
        end else if (state == ST_DRAIN && state_nxt == ST_LOAD) begin
            ld_cnt <= '0;
        end else if (ld_write && ld_cnt != CNT_MAX) begin
            ld_cnt <= ld_cnt + 1'b1;
        end
    end

    // Response register: load on accept, hold while stalled, retire on handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            rsp_perr  <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            if (req_in_range) begin
                rsp_data <= rd_word[DATA_WIDTH-1:0];
                rsp_err  <= 1'b0;
                rsp_perr <= rd_perr;
            end else begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
                rsp_perr <= 1'b0;
            end
        end else if (rsp_fire) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: doc/imem_fetch_port.md
Name: imem_fetch_port

Overview:
Parametrised successor to the single-port instruction ROM. Adds a host load port for program download, a valid/ready fetch request/response interface with backpressure, out-of-range detection, and a LOAD/RUN/DRAIN mode FSM. Sits between the program loader (host/debug path) and the CPU fetch stage.

Parameters:
DEPTH, 256, number of instruction words implemented (1..2**ADDR_WIDTH).
DATA_WIDTH, 16, instruction word width in bits.
ADDR_WIDTH, 8, address width of the load and fetch ports.

Ports:
clk  in  1  single clock; all logic on posedge.
rstn  in  1  asynchronous active-low reset.
ld_en  in  1  load write strobe; accepted only in LOAD state.
ld_addr  in  ADDR_WIDTH  load word address.
ld_data  in  DATA_WIDTH  load word data.
ld_done  in  1  pulse: end program download, go to RUN.
ld_start  in  1  pulse: request return to LOAD.
ld_cnt  out  ADDR_WIDTH+1  in-range words written this LOAD session, saturating.
mode  out  2  state: 00 LOAD, 01 RUN, 10 DRAIN.
req_valid  in  1  fetch request valid.
req_ready  out  1  fetch request accepted when valid&ready.
req_addr  in  ADDR_WIDTH  fetch address.
rsp_valid  out  1  response valid.
rsp_ready  in  1  consumer accepts response.
rsp_data  out  DATA_WIDTH  fetched instruction.
rsp_err  out  1  fetch address >= DEPTH.
rsp_perr  out  1  parity error (see Optional Feature).

Behaviour:
- Reset (rstn low, async): state LOAD, rsp_valid 0, rsp_data 0, rsp_err 0, rsp_perr 0, ld_cnt 0. Memory array is not reset.
- FSM:
  - LOAD -> RUN on ld_done. If ld_en and ld_done are high in the same cycle, the write is performed, then RUN.
  - RUN -> DRAIN on ld_start.
  - DRAIN -> LOAD when rsp_valid is 0, or rsp_valid&rsp_ready this cycle.
  - ld_start in LOAD/DRAIN and ld_done in RUN/DRAIN are ignored.
- Load port:
  - In LOAD, ld_en with ld_addr < DEPTH writes mem[ld_addr] at the edge and increments ld_cnt (saturating at 2**ADDR_WIDTH).
  - ld_addr >= DEPTH: write dropped, ld_cnt unchanged.
  - ld_en in RUN/DRAIN is ignored.
  - ld_cnt clears on entry to LOAD from DRAIN.
- Fetch:
  - req_ready = (state==RUN) & (!rsp_valid | rsp_ready), combinational.
  - Accept at edge with valid&ready. Next cycle rsp_valid=1, with rsp_data=mem[req_addr] and rsp_err=0, or rsp_data=0 and rsp_err=1 if req_addr >= DEPTH.
  - Latency 1 cycle; back-to-back throughput 1/cycle while rsp_ready=1.
- Stall: while rsp_valid&!rsp_ready, rsp_data, rsp_err and rsp_perr hold stable and no memory read occurs.
- rsp_valid clears after rsp_valid&rsp_ready if no new accept happens in that cycle.
- The response pending at ld_start completes normally in DRAIN; no new accepts occur there.
- Reset mid-operation: any pending response is discarded (rsp_valid 0 immediately); memory contents are preserved.

Optional Feature:
- Macro IMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed from ld_data on write.
  - On fetch, parity is recomputed; mismatch sets rsp_perr=1 alongside rsp_valid.
  - rsp_perr=0 for out-of-range fetches.
  - Memory width is DATA_WIDTH+1.
- Undefined: no parity storage; rsp_perr tied 0.

Test Plan:
- Reset, then load 0x1234@0, 0xABCD@1, 0x0F0F@255, ld_done -> ld_cnt=3, mode=01. Fetch addr 1 -> rsp_valid exactly 1 cycle later with rsp_data=0xABCD, rsp_err=0.
- RUN with rsp_ready=1, requests 0,1,255 on consecutive cycles -> three consecutive responses 0x1234, 0xABCD, 0x0F0F, req_ready constantly 1.
- Hold rsp_ready=0 for 4 cycles with a response pending -> req_ready=0, rsp_data stable 0x1234. Release -> next request accepted that same cycle.
- DEPTH=200: fetch addr 210 -> rsp_err=1, rsp_data=0. Load to addr 210 in LOAD -> ld_cnt unchanged.
- ld_start while a response is stalled -> mode=10, req_ready=0. After rsp handshake -> mode=00 and ld_cnt=0. ld_en in RUN -> memory unchanged on read-back.
- With IMEM_PARITY_EN: force a bit flip in stored word 0, then fetch 0 -> rsp_perr=1. Without the macro -> rsp_perr=0.
